audio_capture: RTL and testbench
================================

// Module: audio_capture
// PURPOSE
//   Record path: return direction of the playback mixer. Accepts left/right ADC sample streams
//   (valid/ready), assembles stereo frames, and pushes them to the HPS-bound FIFO as either
//   interleaved L,R words or a mono average word. Buffers up to FIFO_DEPTH words. Drops whole
//   frames on overflow, because the codec is real-time and cannot be stalled.
// PARAMETERS
//   DATA_W      32  stream word width (ADC and HPS FIFO)
//   SAMPLE_W    24  signed sample width, left-justified in DATA_W (bits [31:8])
//   FIFO_DEPTH  8   internal buffer depth in words; power of 2, >=2
//   OVF_W       16  width of overflow frame counter
// PORTS
//   audio_clk        in   1         single clock for the block
//   reset            in   1         asynchronous, active-high reset
//   record_in        in   1         1 = capture enabled
//   stereo_in        in   1         1 = push L then R words; 0 = push one mono word
//   adcL_in          in   DATA_W    left ADC sample, left-justified
//   valid_in_adcL    in   1         left sample valid
//   ready_out_adcL   out  1         left sample accepted when valid&ready
//   adcR_in          in   DATA_W    right ADC sample, left-justified
//   valid_in_adcR    in   1         right sample valid
//   ready_out_adcR   out  1         right sample accepted when valid&ready
//   fifo_out         out  DATA_W    word to HPS FIFO
//   valid_out_fifo   out  1         fifo_out valid
//   ready_in_fifo    in   1         HPS FIFO accepts word when valid&ready
//   overflow_cnt     out  OVF_W     dropped-frame count; saturates at all-ones
// BEHAVIOUR
//   Reset: all outputs 0, FSM=CAP, both sample latches empty, FIFO empty, overflow_cnt=0.
//   FSM states: CAP, CHECK, WR_L, WR_R, WR_M.
//   CAP:
//     - ready_out_adcL = record_in & !haveL; ready_out_adcR = record_in & !haveR.
//     - An accepted beat latches adc*_in[31:8] and sets have*. L and R may arrive in either
//       order or in the same cycle.
//     - When haveL & haveR, go to CHECK next cycle. Both readies are 0 outside CAP.
//   CHECK (1 cycle):
//     - Sample stereo_in once; it is held for the whole frame. Need n = 2 (stereo) or 1 (mono).
//     - If free words >= n, go to WR_L (stereo) or WR_M (mono).
//     - Otherwise drop the frame: clear have*, overflow_cnt += 1 (saturating), return to CAP.
//     - Free count uses occupancy at the start of the cycle. A same-cycle HPS read is not
//       credited.
//   WR_L: write {L,8'h0}, go to WR_R. WR_R: write {R,8'h0}, clear have*, go to CAP.
//   WR_M: write {avg,8'h0}, where avg = (sext(L)+sext(R)) >>> 1. The 25-bit signed sum is
//     floored (arithmetic shift), so there is no overflow. Clear have*, go to CAP.
//   Frames are atomic: once CHECK passes, both stereo words are written. The room check
//     guarantees no write ever hits a full FIFO.
//   record_in falls:
//     - In CAP: readies drop the same cycle and have* clear next cycle (partial frame discarded).
//     - In CHECK/WR_*: the frame completes, then the block idles in CAP.
//   FIFO output is first-word-fall-through:
//     - valid_out_fifo = !empty; fifo_out = head word.
//     - A word written in cycle N is visible in cycle N+1.
//     - The HPS read (valid&ready) pops. Simultaneous read and write are both honoured.
//     - Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
//     - The FIFO keeps draining while record_in=0.
//   Throughput: one frame per 3 cycles (stereo) or 2 cycles (mono) plus ADC arrival time.
//   Async reset mid-frame discards latches and FIFO contents immediately.
// STRUCTURE
//   audio_defs.vh (shared): SAMPLE_W/shift constants, FSM state encodings, left-justify macro.
//   Sub-module capture_fifo: parameterised sync FWFT FIFO. Ports: wr_en/wr_data, rd_en,
//     rd_data, empty, and a count output for the room check.
//   Top level: FSM, L/R latches, mono averager, overflow counter.
// TESTING
//   1 Stereo, ready_in_fifo=1; L=0x12345600, R=0xFEDCBA00
//      -> fifo_out 0x12345600 then 0xFEDCBA00 on consecutive cycles.
//   2 Mono; L=0x7FFFFF00, R=0x7FFFFF00 -> 0x7FFFFF00.
//      L=0x80000000, R=0x00000100 -> 0xC0000000 (floor of -8388607/2 = -4194304).
//   3 R beat arrives before L, and a later frame with L,R in the same cycle
//      -> each frame is output in L,R order, with no beat lost or duplicated.
//   4 ready_in_fifo=0, stereo, DEPTH=8; send 5 frames
//      -> 4 frames buffered (valid_out_fifo=1), 5th dropped, overflow_cnt=1.
//      Then ready_in_fifo=1 -> exactly 8 words drained in order.
//   5 Drop record_in after L accepted but before R
//      -> readies go 0, nothing written; after re-enable the next frame has fresh L and R.
//   6 Assert reset while in WR_R with 3 words buffered
//      -> all outputs 0 and overflow_cnt=0 immediately; no stale word appears after release.
//      Separately force 2^OVF_W+3 drops -> counter holds at all-ones.

Source files
------------

// File: rtl/audio_capture_pkg.sv
// Shared types and default sizing for the record path.
// Imported by the capture FSM and its word FIFO.
package audio_capture_pkg;

  localparam int DATA_W_D     = 32;
  localparam int SAMPLE_W_D   = 24;
  localparam int FIFO_DEPTH_D = 8;
  localparam int OVF_W_D      = 16;

  typedef enum logic [2:0] {
    ST_CAP,
    ST_CHECK,
    ST_WR_L,
    ST_WR_R,
    ST_WR_M
  } state_t;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_capture_fifo.sv
// Synchronous first-word-fall-through word FIFO.
// Head word reads as zero while empty.
module audio_capture_fifo
  import audio_capture_pkg::*;
#(
  parameter int DW    = DATA_W_D,
  parameter int DEPTH = FIFO_DEPTH_D,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Extra pointer MSB separates full from empty.
  assign w_full = (r_wp[AW] != r_rp[AW]) &&
                  (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign empty  = (r_wp == r_rp);
  assign count  = r_wp - r_rp;
  assign w_push = wr_en & ~w_full;
  assign w_pop  = rd_en & ~empty;

  assign rd_data = empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_capture.sv
// Record path: pairs L/R ADC beats into frames and queues them
// as interleaved or averaged words; whole frames drop on no room.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int SAMPLE_W   = SAMPLE_W_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int OVF_W      = OVF_W_D
) (
  input  logic              audio_clk,
  input  logic              reset,
  input  logic              record_in,
  input  logic              stereo_in,
  input  logic [DATA_W-1:0] adcL_in,
  input  logic              valid_in_adcL,
  output logic              ready_out_adcL,
  input  logic [DATA_W-1:0] adcR_in,
  input  logic              valid_in_adcR,
  output logic              ready_out_adcR,
  output logic [DATA_W-1:0] fifo_out,
  output logic              valid_out_fifo,
  input  logic              ready_in_fifo,
  output logic [OVF_W-1:0]  overflow_cnt
);

  localparam int SHIFT = DATA_W - SAMPLE_W;
  localparam int CW    = fifo_cw(FIFO_DEPTH);

  state_t              r_state;
  logic                r_have_l;
  logic                r_have_r;
  logic [SAMPLE_W-1:0] r_l;
  logic [SAMPLE_W-1:0] r_r;
  logic [OVF_W-1:0]    r_ovf;

  logic                w_cap;
  logic                w_acc_l;
  logic                w_acc_r;
  logic                w_room;
  logic                w_wr_en;
  logic                w_empty;
  logic [CW-1:0]       w_cnt;
  logic [CW-1:0]       w_free;
  logic [SAMPLE_W:0]   w_sum;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_unused;

  assign w_unused = ^{adcL_in[SHIFT-1:0], adcR_in[SHIFT-1:0]};

  assign w_cap          = (r_state == ST_CAP) & ~reset;
  assign ready_out_adcL = w_cap & record_in & ~r_have_l;
  assign ready_out_adcR = w_cap & record_in & ~r_have_r;
  assign w_acc_l        = valid_in_adcL & ready_out_adcL;
  assign w_acc_r        = valid_in_adcR & ready_out_adcR;

  // Room uses start-of-cycle occupancy; a same-cycle pop is ignored.
  assign w_free = CW'(FIFO_DEPTH) - w_cnt;
  assign w_room = stereo_in ? (w_free >= CW'(2))
                            : (w_free >= CW'(1));

  // 25-bit sum then drop LSB: floored average, never overflows.
  assign w_sum = {r_l[SAMPLE_W-1], r_l} + {r_r[SAMPLE_W-1], r_r};

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    unique case (r_state)
      ST_WR_L: begin
        w_wr_en   = 1'b1;
        w_wr_data = {r_l, {SHIFT{1'b0}}};
      end
      ST_WR_R: begin
        w_wr_en   = 1'b1;
        w_wr_data = {r_r, {SHIFT{1'b0}}};
      end
      ST_WR_M: begin
        w_wr_en   = 1'b1;
        w_wr_data = {w_sum[SAMPLE_W:1], {SHIFT{1'b0}}};
      end
      default: begin
        w_wr_en   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge audio_clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_CAP;
      r_have_l <= 1'b0;
      r_have_r <= 1'b0;
      r_l      <= '0;
      r_r      <= '0;
      r_ovf    <= '0;
    end else begin
      unique case (r_state)
        ST_CAP: begin
          if (!record_in) begin
            r_have_l <= 1'b0;
            r_have_r <= 1'b0;
          end else begin
            if (w_acc_l) begin
              r_l      <= adcL_in[DATA_W-1:SHIFT];
              r_have_l <= 1'b1;
            end
            if (w_acc_r) begin
              r_r      <= adcR_in[DATA_W-1:SHIFT];
              r_have_r <= 1'b1;
            end
            if ((r_have_l | w_acc_l) & (r_have_r | w_acc_r)) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_room) begin
            r_state <= stereo_in ? ST_WR_L : ST_WR_M;
          end else begin
            r_have_l <= 1'b0;
            r_have_r <= 1'b0;
            r_state  <= ST_CAP;
            if (r_ovf != {OVF_W{1'b1}}) begin
              r_ovf <= r_ovf + 1'b1;
            end
          end
        end
        ST_WR_L: begin
          r_state <= ST_WR_R;
        end
        ST_WR_R, ST_WR_M: begin
          r_have_l <= 1'b0;
          r_have_r <= 1'b0;
          r_state  <= ST_CAP;
        end
        default: begin
          r_state <= ST_CAP;
        end
      endcase
    end
  end

  audio_capture_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (audio_clk),
    .rst     (reset),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_data),
    .rd_en   (ready_in_fifo),
    .rd_data (w_rd_data),
    .empty   (w_empty),
    .count   (w_cnt)
  );

  assign fifo_out       = w_rd_data;
  assign valid_out_fifo = ~w_empty;
  assign overflow_cnt   = r_ovf;

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: frame order, mono average,
// overflow drops, record abort, async reset and counter saturation.
module tb_audio_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec = 1'b0;
  logic        ster = 1'b1;
  logic [31:0] adc_l = '0;
  logic        v_l = 1'b0;
  logic        rdy_l;
  logic [31:0] adc_r = '0;
  logic        v_r = 1'b0;
  logic        rdy_r;
  logic [31:0] fo;
  logic        vo;
  logic        rf = 1'b1;
  logic [7:0]  ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] q_w[$];
  int          q_c[$];
  logic [31:0] e_q[$];

  always #5 clk = ~clk;

  audio_capture #(.OVF_W(8)) dut (
    .audio_clk      (clk),
    .reset          (rst),
    .record_in      (rec),
    .stereo_in      (ster),
    .adcL_in        (adc_l),
    .valid_in_adcL  (v_l),
    .ready_out_adcL (rdy_l),
    .adcR_in        (adc_r),
    .valid_in_adcR  (v_r),
    .ready_out_adcR (rdy_r),
    .fifo_out       (fo),
    .valid_out_fifo (vo),
    .ready_in_fifo  (rf),
    .overflow_cnt   (ovf)
  );

  // Handshake is stable across the low phase; log pops there.
  always @(negedge clk) begin
    cyc++;
    if (!rst && vo && rf) begin
      q_w.push_back(fo);
      q_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  task automatic acc(input bit nl, input bit nr);
    int n;
    n = 0;
    #1;
    while (!((!nl || rdy_l) && (!nr || rdy_r)) && n < 50) begin
      tick;
      n++;
    end
    chk("acc_to", 32'(n < 50), 32'd1);
  endtask

  // mode 0: same cycle, 1: L then R, 2: R then L
  task automatic push(input logic [31:0] l,
                      input logic [31:0] r,
                      input int mode);
    adc_l = l;
    adc_r = r;
    if (mode == 0) begin
      v_l = 1'b1;
      v_r = 1'b1;
      acc(1'b1, 1'b1);
      tick;
      v_l = 1'b0;
      v_r = 1'b0;
    end else if (mode == 1) begin
      v_l = 1'b1;
      acc(1'b1, 1'b0);
      tick;
      v_l = 1'b0;
      v_r = 1'b1;
      acc(1'b0, 1'b1);
      tick;
      v_r = 1'b0;
    end else begin
      v_r = 1'b1;
      acc(1'b0, 1'b1);
      tick;
      v_r = 1'b0;
      v_l = 1'b1;
      acc(1'b1, 1'b0);
      tick;
      v_l = 1'b0;
    end
    tick;
  endtask

  task automatic clrq;
    q_w.delete();
    q_c.delete();
    e_q.delete();
  endtask

  task automatic expect_q(input string tag);
    chk({tag, "_n"}, 32'(q_w.size()), 32'(e_q.size()));
    foreach (e_q[i]) begin
      chk(tag, (i < q_w.size()) ? q_w[i] : 32'hxxxxxxxx, e_q[i]);
    end
    clrq();
  endtask

  initial begin
    rec = 1'b1;
    #2;
    chk("rst_rdyl", 32'(rdy_l), 32'd0);
    chk("rst_vo", 32'(vo), 32'd0);
    chk("rst_fo", fo, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    idle(2);
    rst = 1'b0;
    tick;
    chk("idle_rdyl", 32'(rdy_l), 32'd1);
    clrq();

    // 1: stereo, words back to back
    ster = 1'b1;
    push(32'h12345600, 32'hFEDCBA00, 0);
    idle(5);
    if (q_c.size() >= 2) begin
      chk("t1_consec", 32'(q_c[1] - q_c[0]), 32'd1);
    end
    e_q.push_back(32'h12345600);
    e_q.push_back(32'hFEDCBA00);
    expect_q("t1");

    // 2: mono averages, floor on negative
    ster = 1'b0;
    push(32'h7FFFFF00, 32'h7FFFFF00, 0);
    push(32'h80000000, 32'h00000100, 1);
    idle(4);
    e_q.push_back(32'h7FFFFF00);
    e_q.push_back(32'hC0000000);
    expect_q("t2");

    // 3: R first, then same cycle with junk low bits
    ster = 1'b1;
    push(32'h11111100, 32'h22222200, 2);
    push(32'h333333FF, 32'h444444EE, 0);
    idle(5);
    e_q.push_back(32'h11111100);
    e_q.push_back(32'h22222200);
    e_q.push_back(32'h33333300);
    e_q.push_back(32'h44444400);
    expect_q("t3");

    // 4: stalled sink, 5th frame dropped
    rf = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(32'h10000000 + (k << 8), 32'h20000000 + (k << 8), 0);
    end
    idle(3);
    chk("t4_vo", 32'(vo), 32'd1);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_head", fo, 32'h10000100);
    rf = 1'b1;
    idle(12);
    for (int k = 1; k <= 4; k++) begin
      e_q.push_back(32'h10000000 + (k << 8));
      e_q.push_back(32'h20000000 + (k << 8));
    end
    expect_q("t4");
    chk("t4_empty", 32'(vo), 32'd0);

    // 5: record drops mid-frame
    adc_l = 32'h55555500;
    v_l = 1'b1;
    acc(1'b1, 1'b0);
    tick;
    v_l = 1'b0;
    chk("t5_rdyl_hold", 32'(rdy_l), 32'd0);
    rec = 1'b0;
    #1;
    chk("t5_rdyr_off", 32'(rdy_r), 32'd0);
    idle(2);
    rec = 1'b1;
    #1;
    chk("t5_rdyl_back", 32'(rdy_l), 32'd1);
    push(32'hAAAAAA00, 32'hBBBBBB00, 1);
    idle(5);
    e_q.push_back(32'hAAAAAA00);
    e_q.push_back(32'hBBBBBB00);
    expect_q("t5");

    // 6: reset during WR_R with 3 words queued
    rf = 1'b0;
    ster = 1'b0;
    push(32'h00000200, 32'h00000400, 0);
    push(32'hFFFFFF00, 32'h00000000, 0);
    ster = 1'b1;
    adc_l = 32'h0A0A0A00;
    adc_r = 32'h0B0B0B00;
    v_l = 1'b1;
    v_r = 1'b1;
    acc(1'b1, 1'b1);
    tick;
    v_l = 1'b0;
    v_r = 1'b0;
    idle(2);
    chk("t6_vo_pre", 32'(vo), 32'd1);
    chk("t6_fo_pre", fo, 32'h00000300);
    chk("t6_ovf_pre", 32'(ovf), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_vo", 32'(vo), 32'd0);
    chk("t6_fo", fo, 32'h0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_rdyl", 32'(rdy_l), 32'd0);
    tick;
    rst = 1'b0;
    idle(4);
    chk("t6_vo_post", 32'(vo), 32'd0);
    rf = 1'b1;
    idle(3);
    expect_q("t6");

    // boundary: 7 words used, stereo drops, mono fits
    rf = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push(32'h30000000 + (k << 8), 32'h40000000 + (k << 8), 0);
    end
    ster = 1'b0;
    push(32'h00001000, 32'h00000000, 0);
    ster = 1'b1;
    push(32'h77777700, 32'h66666600, 0);
    idle(2);
    chk("b_ovf1", 32'(ovf), 32'd1);
    ster = 1'b0;
    push(32'hFFFFFE00, 32'hFFFFFF00, 0);
    idle(2);
    chk("b_mono_fit", 32'(ovf), 32'd1);
    ster = 1'b1;
    for (int k = 0; k < 300; k++) begin
      push(32'h5A5A5A00, 32'hA5A5A500, 0);
    end
    idle(2);
    chk("sat_ovf", 32'(ovf), 32'd255);
    rf = 1'b1;
    idle(12);
    for (int k = 1; k <= 3; k++) begin
      e_q.push_back(32'h30000000 + (k << 8));
      e_q.push_back(32'h40000000 + (k << 8));
    end
    e_q.push_back(32'h00000800);
    e_q.push_back(32'hFFFFFE00);
    expect_q("b_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
